// File: rtl/hazard_fwd_ctrl_pkg.sv
// hazard_fwd_ctrl_pkg
// Shared definitions for the hazard/forwarding controller: controller state
// encoding, operand-mux select codes and the hard-wired zero register index.
package hazard_fwd_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    LU_STALL  = 2'd1,
    BR_FLUSH  = 2'd2,
    RAW_STALL = 2'd3
  } state_t;

  // Operand mux selects
  localparam logic [1:0] FWD_REG = 2'b00;  // ID/EX register value
  localparam logic [1:0] FWD_WB  = 2'b01;  // WB result
  localparam logic [1:0] FWD_MEM = 2'b10;  // EX/MEM ALU result

  // Register x0 is hard-wired to zero: it never forwards nor stalls
  localparam int unsigned X0_IDX = 0;

endpackage

// File: rtl/hazard_fwd_ctrl_fwd_sel.sv
// fwd_sel
// Forwarding select for one EX operand. The youngest producer (MEM) wins over
// WB; a match on x0 never forwards.
// Ports:
//   rs_ex        - source index of the operand in EX
//   rd_mem/rd_wb - destination indices in MEM / WB
//   regwrite_mem/regwrite_wb - write enables in MEM / WB
//   sel          - FWD_REG / FWD_WB / FWD_MEM
module fwd_sel
  import hazard_fwd_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs_ex,
  input  logic [REG_ADDR_W-1:0] rd_mem,
  input  logic [REG_ADDR_W-1:0] rd_wb,
  input  logic                  regwrite_mem,
  input  logic                  regwrite_wb,
  output logic [1:0]            sel
);

  always_comb begin
    sel = FWD_REG;
    if (regwrite_mem && (rd_mem != REG_ADDR_W'(X0_IDX)) && (rd_mem == rs_ex))
      sel = FWD_MEM;
    else if (regwrite_wb && (rd_wb != REG_ADDR_W'(X0_IDX)) && (rd_wb == rs_ex))
      sel = FWD_WB;
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl
// Hazard detection and forwarding control for a 5-stage in-order pipeline.
// Configuration macro: HAZARD_FWD_CTRL_FWD_EN
//   defined   - EX operands forwarded from MEM/WB; only load-use stalls (1 bubble)
//   undefined - no forwarding (selects tied to 00); RAW hazards stall until the
//               producer reaches WB (2 cycles from EX, 1 cycle from MEM)
// Ports:
//   clk, reset (async, active-high)
//   rs1_id/rs2_id, rs1_ex/rs2_ex, rd_ex/rd_mem/rd_wb - register indices
//   regwrite_ex/mem/wb, memread_ex, branch_taken_ex  - stage control flags
//   forward_a/forward_b - operand mux selects
//   stall_if/stall_id/flush_id/flush_ex - pipeline hold/bubble controls
//   stall_count - saturating count of stalled cycles
module hazard_fwd_ctrl
  import hazard_fwd_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] rs1_id,
  input  logic [REG_ADDR_W-1:0] rs2_id,
  input  logic [REG_ADDR_W-1:0] rs1_ex,
  input  logic [REG_ADDR_W-1:0] rs2_ex,
  input  logic [REG_ADDR_W-1:0] rd_ex,
  input  logic [REG_ADDR_W-1:0] rd_mem,
  input  logic [REG_ADDR_W-1:0] rd_wb,
  input  logic                  regwrite_ex,
  input  logic                  regwrite_mem,
  input  logic                  regwrite_wb,
  input  logic                  memread_ex,
  input  logic                  branch_taken_ex,
  output logic [1:0]            forward_a,
  output logic [1:0]            forward_b,
  output logic                  stall_if,
  output logic                  stall_id,
  output logic                  flush_id,
  output logic                  flush_ex,
  output logic [CNT_W-1:0]      stall_count
);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_count;
  logic             w_stall;
  logic             w_flush_id;
  logic             w_flush_ex;
  logic             w_unused;

  // Does the given producer index feed a source of the instruction in ID?
  function automatic logic id_reads(input logic [REG_ADDR_W-1:0] rd);
    return (rd != REG_ADDR_W'(X0_IDX)) && ((rd == rs1_id) || (rd == rs2_id));
  endfunction

`ifdef HAZARD_FWD_CTRL_FWD_EN
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;
  logic       w_lu_hz;

  fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .rs_ex(rs1_ex), .rd_mem(rd_mem), .rd_wb(rd_wb),
    .regwrite_mem(regwrite_mem), .regwrite_wb(regwrite_wb), .sel(w_fwd_a)
  );
  fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .rs_ex(rs2_ex), .rd_mem(rd_mem), .rd_wb(rd_wb),
    .regwrite_mem(regwrite_mem), .regwrite_wb(regwrite_wb), .sel(w_fwd_b)
  );

  assign w_lu_hz   = memread_ex && id_reads(rd_ex);
  assign forward_a = reset ? FWD_REG : w_fwd_a;
  assign forward_b = reset ? FWD_REG : w_fwd_b;
  assign w_unused  = regwrite_ex;
`else
  logic w_ex_hz;
  logic w_mem_hz;

  // A load also writes its rd, so it counts as an EX producer here
  assign w_ex_hz   = (regwrite_ex || memread_ex) && id_reads(rd_ex);
  assign w_mem_hz  = regwrite_mem && id_reads(rd_mem);
  assign forward_a = FWD_REG;
  assign forward_b = FWD_REG;
  assign w_unused  = ^{rs1_ex, rs2_ex, rd_wb, regwrite_wb};
`endif

  // BR_FLUSH and RAW_STALL follow a bubble injected into EX, so ID/EX inputs
  // are not evaluated in those states.
  always_comb begin
    w_stall    = 1'b0;
    w_flush_id = 1'b0;
    w_flush_ex = 1'b0;
    w_next     = RUN;
    case (r_state)
      BR_FLUSH: begin
        w_flush_id = 1'b1;
      end
      RAW_STALL: begin
        w_stall    = 1'b1;
        w_flush_ex = 1'b1;
      end
      default: begin
        if (branch_taken_ex) begin
          w_flush_id = 1'b1;
          w_flush_ex = 1'b1;
          w_next     = BR_FLUSH;
        end
`ifdef HAZARD_FWD_CTRL_FWD_EN
        else if (w_lu_hz) begin
          w_stall    = 1'b1;
          w_flush_ex = 1'b1;
          w_next     = (r_state == RUN) ? LU_STALL : RUN;
        end
`else
        else if (w_ex_hz) begin
          w_stall    = 1'b1;
          w_flush_ex = 1'b1;
          w_next     = RAW_STALL;
        end else if (w_mem_hz) begin
          w_stall    = 1'b1;
          w_flush_ex = 1'b1;
        end
`endif
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RUN;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      if (w_stall && (r_count != '1))
        r_count <= r_count + CNT_W'(1);
    end
  end

  // Gate with reset so input matches cannot leak through while in reset
  assign stall_if    = w_stall & ~reset;
  assign stall_id    = w_stall & ~reset;
  assign flush_id    = w_flush_id & ~reset;
  assign flush_ex    = w_flush_ex & ~reset;
  assign stall_count = r_count;

endmodule
